// File: rtl/sorted_lists_table.sv
// ID_N independent 4-entry lists kept sorted by an external 3-stage network; 4-cycle per-ID turnaround.
// A command is held off (cmd_rdy low) only while its own ID has a sort in flight; other IDs may issue back-to-back.
package sorted_lists_pkg;
   localparam int KEY_W  = 8;
   localparam int DATA_W = 8;
   localparam int LIST_N = 4;

   typedef struct packed {
      logic              vld;
      logic [KEY_W-1:0]  key;
      logic [DATA_W-1:0] data;
   } entry_t;

   typedef struct packed {
      entry_t [LIST_N-1:0] e;
   } table_state_t;

   typedef enum logic [1:0] {
      OP_CLEAR  = 2'd0,
      OP_INSERT = 2'd1,
      OP_DELETE = 2'd2,
      OP_NOP    = 2'd3
   } op_t;
endpackage

module sorted_lists_table
   import sorted_lists_pkg::*;
#(
   parameter int ID_N = 4,
   localparam int ID_W = (ID_N > 1) ? $clog2(ID_N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_vld,
   output logic            cmd_rdy,
   input  logic [1:0]      cmd_op,
   input  logic [ID_W-1:0] cmd_id,
   input  entry_t          cmd_entry,
   output logic            unsorted_valid,
   output table_state_t    unsorted,
   input  table_state_t    sorted_r,
   input  logic            rd_en,
   input  logic [ID_W-1:0] rd_id,
   output logic            rd_vld,
   output table_state_t    rd_state
);

   table_state_t    tbl [ID_N];
   logic [ID_N-1:0] pending;
   logic [ID_N-1:0] pending_nxt;
   logic [2:0]      stg_vld;
   logic [ID_W-1:0] stg_id [3];

   logic            accept;
   logic            issue;
   logic            wb_vld;
   logic [ID_W-1:0] wb_id;
   table_state_t    cur;
   table_state_t    nxt;
   entry_t          ins;
   logic            free_found;

   assign cmd_rdy = !pending[cmd_id];
   assign accept  = cmd_vld && cmd_rdy;
   assign issue   = accept && (op_t'(cmd_op) != OP_NOP);
   assign wb_vld  = stg_vld[2];
   assign wb_id   = stg_id[2];

   // No sort is in flight for cmd_id whenever it is accepted, so the stored table is current.
   always_comb begin
      cur        = tbl[cmd_id];
      nxt        = cur;
      ins        = cmd_entry;
      ins.vld    = 1'b1;
      free_found = 1'b0;
      case (op_t'(cmd_op))
         OP_CLEAR: begin
            nxt = '0;
         end
         OP_INSERT: begin
            for (int i = 0; i < LIST_N; i++) begin
               if (!free_found && !cur.e[i].vld) begin
                  nxt.e[i]   = ins;
                  free_found = 1'b1;
               end
            end
            // Full list: e[3] holds the smallest key, so it is the only eviction candidate.
            if (!free_found && (cmd_entry.key > cur.e[LIST_N-1].key)) begin
               nxt.e[LIST_N-1] = ins;
            end
         end
         OP_DELETE: begin
            for (int i = 0; i < LIST_N; i++) begin
               if (cur.e[i].key == cmd_entry.key) begin
                  nxt.e[i].vld = 1'b0;
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      pending_nxt = pending;
      for (int i = 0; i < ID_N; i++) begin
         if (wb_vld && (wb_id == ID_W'(i))) begin
            pending_nxt[i] = 1'b0;
         end
         if (issue && (cmd_id == ID_W'(i))) begin
            pending_nxt[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         unsorted_valid <= 1'b0;
         unsorted       <= '0;
         pending        <= '0;
         stg_vld        <= '0;
         stg_id[0]      <= '0;
         stg_id[1]      <= '0;
         stg_id[2]      <= '0;
      end else begin
         unsorted_valid <= issue;
         if (issue) begin
            unsorted <= nxt;
         end
         pending   <= pending_nxt;
         // Stage 1 coincides with unsorted_valid; stage 3 lines up with sorted_r.
         stg_vld   <= {stg_vld[1:0], issue};
         stg_id[0] <= cmd_id;
         stg_id[1] <= stg_id[0];
         stg_id[2] <= stg_id[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ID_N; i++) begin
            tbl[i] <= '0;
         end
      end else if (wb_vld) begin
         tbl[wb_id] <= sorted_r;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_vld   <= 1'b0;
         rd_state <= '0;
      end else begin
         rd_vld <= rd_en;
         if (rd_en) begin
            rd_state <= (wb_vld && (wb_id == rd_id)) ? sorted_r : tbl[rd_id];
         end
      end
   end

endmodule

// File: tb/tb_sorted_lists_table.sv
// Directed bench for sorted_lists_table with a behavioural sorting network (sorted_r valid 2 edges after unsorted).
module tb_sorted_lists_table;
   import sorted_lists_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_vld;
   logic         cmd_rdy;
   logic [1:0]   cmd_op;
   logic [1:0]   cmd_id;
   entry_t       cmd_entry;
   logic         unsorted_valid;
   table_state_t unsorted;
   table_state_t sorted_r;
   table_state_t net_s1;
   logic         rd_en;
   logic [1:0]   rd_id;
   logic         rd_vld;
   table_state_t rd_state;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sorted_lists_table #(.ID_N(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_id(cmd_id), .cmd_entry(cmd_entry),
      .unsorted_valid(unsorted_valid), .unsorted(unsorted), .sorted_r(sorted_r),
      .rd_en(rd_en), .rd_id(rd_id), .rd_vld(rd_vld), .rd_state(rd_state)
   );

   function automatic table_state_t net_sort(input table_state_t s);
      entry_t a [4];
      entry_t t;
      table_state_t r;
      for (int i = 0; i < 4; i++) a[i] = s.e[i];
      for (int p = 0; p < 3; p++) begin
         for (int j = 0; j < 3; j++) begin
            if ({a[j+1].vld, a[j+1].key} > {a[j].vld, a[j].key}) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
         end
      end
      for (int i = 0; i < 4; i++) r.e[i] = a[i];
      return r;
   endfunction

   always @(posedge clk) begin
      net_s1   <= net_sort(unsorted);
      sorted_r <= net_s1;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input table_state_t s, input logic [3:0] ev,
                            input logic [7:0] k0, input logic [7:0] k1,
                            input logic [7:0] k2, input logic [7:0] k3);
      logic [3:0] v;
      logic [7:0] k [4];
      k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
      for (int i = 0; i < 4; i++) v[i] = s.e[i].vld;
      chk({tag, "_vld"}, 16'(v), 16'(ev));
      for (int i = 0; i < 4; i++) begin
         if (ev[i]) chk($sformatf("%s_key%0d", tag, i), 16'(s.e[i].key), 16'(k[i]));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle command; returns at the negedge of the cycle after acceptance.
   task automatic send(input logic [1:0] op, input logic [1:0] id, input logic [7:0] key);
      @(negedge clk);
      cmd_vld = 1'b1; cmd_op = op; cmd_id = id;
      cmd_entry = '{vld: 1'b0, key: key, data: key + 8'd1};
      #1 chk("rdy_at_issue", 16'(cmd_rdy), 16'd1);
      @(negedge clk);
      cmd_vld = 1'b0;
   endtask

   task automatic read_list(input logic [1:0] id, input string tag, input logic [3:0] ev,
                            input logic [7:0] k0, input logic [7:0] k1,
                            input logic [7:0] k2, input logic [7:0] k3);
      @(negedge clk);
      rd_en = 1'b1; rd_id = id;
      @(negedge clk);
      rd_en = 1'b0;
      chk({tag, "_rdvld"}, 16'(rd_vld), 16'd1);
      chk_state(tag, rd_state, ev, k0, k1, k2, k3);
   endtask

   initial begin
      rst = 1'b1; cmd_vld = 1'b0; cmd_op = 2'd3; cmd_id = 2'd0; cmd_entry = '0;
      rd_en = 1'b0; rd_id = 2'd0;
      idle(2);
      chk("rst_rdy", 16'(cmd_rdy), 16'd1);
      chk("rst_uv", 16'(unsorted_valid), 16'd0);
      chk("rst_rdvld", 16'(rd_vld), 16'd0);
      chk_state("rst_rdstate", rd_state, 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);
      rst = 1'b0;
      idle(1);

      // Insert 5, 9, 2 into id0 at 4-cycle spacing.
      send(2'd1, 2'd0, 8'd5);
      chk("ins_uv", 16'(unsorted_valid), 16'd1);
      chk_state("ins_unsorted", unsorted, 4'b0001, 8'd5, 8'd0, 8'd0, 8'd0);
      chk("ins_data", 16'(unsorted.e[0].data), 16'd6);
      chk("pend_rdy", 16'(cmd_rdy), 16'd0);
      idle(2);
      chk("wb_cycle_rdy", 16'(cmd_rdy), 16'd0);
      send(2'd1, 2'd0, 8'd9);
      idle(2);
      send(2'd1, 2'd0, 8'd2);
      chk("uv_drop", 16'(unsorted_valid), 16'd1);
      idle(1);
      chk("uv_low", 16'(unsorted_valid), 16'd0);
      idle(1);
      read_list(2'd0, "id0_952", 4'b0111, 8'd9, 8'd5, 8'd2, 8'd0);
      idle(1);
      chk("rdvld_pulse", 16'(rd_vld), 16'd0);

      // Full list on id3, then eviction and non-eviction.
      send(2'd1, 2'd3, 8'd9); idle(2);
      send(2'd1, 2'd3, 8'd7); idle(2);
      send(2'd1, 2'd3, 8'd5); idle(2);
      send(2'd1, 2'd3, 8'd3); idle(2);
      read_list(2'd3, "id3_full", 4'b1111, 8'd9, 8'd7, 8'd5, 8'd3);
      send(2'd1, 2'd3, 8'd4); idle(2);
      read_list(2'd3, "id3_ins4", 4'b1111, 8'd9, 8'd7, 8'd5, 8'd4);
      send(2'd1, 2'd3, 8'd1); idle(2);
      read_list(2'd3, "id3_ins1", 4'b1111, 8'd9, 8'd7, 8'd5, 8'd4);
      send(2'd2, 2'd3, 8'd7); idle(2);
      read_list(2'd3, "id3_del7", 4'b0111, 8'd9, 8'd5, 8'd4, 8'd0);
      send(2'd2, 2'd3, 8'd8); idle(2);
      read_list(2'd3, "id3_del8", 4'b0111, 8'd9, 8'd5, 8'd4, 8'd0);

      // NOP issues nothing and leaves id3 ready; CLEAR empties id3.
      send(2'd3, 2'd3, 8'd9);
      chk("nop_uv", 16'(unsorted_valid), 16'd0);
      chk("nop_rdy", 16'(cmd_rdy), 16'd1);
      send(2'd0, 2'd3, 8'd0); idle(2);
      read_list(2'd3, "id3_clr", 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);

      // Back-to-back id0, id1, id2, then id0 held until ready.
      @(negedge clk);
      cmd_vld = 1'b1; cmd_op = 2'd1; cmd_id = 2'd0; cmd_entry = '{vld: 1'b0, key: 8'd1, data: 8'd0};
      #1 chk("b2b_t0_rdy", 16'(cmd_rdy), 16'd1);
      @(negedge clk);
      cmd_id = 2'd0;
      #1 chk("b2b_t1_id0", 16'(cmd_rdy), 16'd0);
      cmd_id = 2'd1; cmd_entry.key = 8'd6;
      #1 chk("b2b_t1_id1", 16'(cmd_rdy), 16'd1);
      @(negedge clk);
      cmd_id = 2'd0;
      #1 chk("b2b_t2_id0", 16'(cmd_rdy), 16'd0);
      cmd_id = 2'd2; cmd_entry.key = 8'd3;
      #1 chk("b2b_t2_id2", 16'(cmd_rdy), 16'd1);
      @(negedge clk);
      cmd_id = 2'd0; cmd_entry.key = 8'd8;
      #1 chk("b2b_t3_id0", 16'(cmd_rdy), 16'd0);
      @(negedge clk);
      #1 chk("b2b_t4_id0", 16'(cmd_rdy), 16'd1);
      @(negedge clk);
      cmd_vld = 1'b0;
      idle(3);
      read_list(2'd0, "b2b_id0", 4'b1111, 8'd9, 8'd8, 8'd5, 8'd2);
      read_list(2'd1, "b2b_id1", 4'b0001, 8'd6, 8'd0, 8'd0, 8'd0);
      read_list(2'd2, "b2b_id2", 4'b0001, 8'd3, 8'd0, 8'd0, 8'd0);

      // Read issued in the write-back cycle of id1 returns the new state.
      send(2'd1, 2'd1, 8'd4);
      idle(2);
      rd_en = 1'b1; rd_id = 2'd1;
      @(negedge clk);
      rd_en = 1'b0;
      chk("byp_rdvld", 16'(rd_vld), 16'd1);
      chk_state("byp", rd_state, 4'b0011, 8'd6, 8'd4, 8'd0, 8'd0);

      // Reset one cycle after an accepted insert discards the write-back.
      send(2'd1, 2'd2, 8'd7);
      rst = 1'b1;
      #1 chk("mid_rst_uv", 16'(unsorted_valid), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      cmd_id = 2'd2;
      #1 chk("post_rst_uv", 16'(unsorted_valid), 16'd0);
      idle(4);
      chk("post_rst_rdy", 16'(cmd_rdy), 16'd1);
      read_list(2'd2, "post_rst_id2", 4'b0000, 8'd0, 8'd0, 8'd0, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
